// File: rtl/key_debounce.sv
// key_debounce: synchronises, debounces and press/release/long-press detects
// a bank of active-low push-button lines on a shared 1 ms tick.
module key_debounce #(
    parameter int F_CLK       = 50000000,
    parameter int N_KEYS      = 6,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);
    localparam int TICK_DIV = F_CLK / 1000;
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_MS);
    localparam int LW = $clog2(LONG_MS + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_MS - 1);
    localparam logic [LW-1:0] LP_MAX = LW'(LONG_MS);

    logic [N_KEYS-1:0] k_m_q, k_s_q;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [DW-1:0]     db_cnt_q [N_KEYS];
    logic [DW-1:0]     db_cnt_d [N_KEYS];
    logic [LW-1:0]     lp_cnt_q [N_KEYS];
    logic [LW-1:0]     lp_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] state_q, state_d, press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d, long_q, long_d;

    assign tick        = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        lp_cnt_d  = lp_cnt_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (k_s_q[i] == state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    state_d[i]   = k_s_q[i];
                    db_cnt_d[i]  = '0;
                    press_d[i]   = ~k_s_q[i];
                    release_d[i] = k_s_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            // Saturating hold counter: exactly one long strobe per hold.
            if (state_q[i]) begin
                lp_cnt_d[i] = '0;
            end else if (tick && lp_cnt_q[i] < LP_MAX) begin
                lp_cnt_d[i] = lp_cnt_q[i] + 1'b1;
                long_d[i]   = (lp_cnt_q[i] == LP_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_m_q      <= '1;
            k_s_q      <= '1;
            tick_cnt_q <= '0;
            db_cnt_q   <= '{default: '0};
            lp_cnt_q   <= '{default: '0};
            state_q    <= '1;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
        end else begin
            k_m_q      <= key;
            k_s_q      <= k_m_q;
            tick_cnt_q <= tick_cnt_d;
            db_cnt_q   <= db_cnt_d;
            lp_cnt_q   <= lp_cnt_d;
            state_q    <= state_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized key stimulus checked every cycle
// against a tick-counting reference model of the debouncer.
module tb_key_debounce;
    localparam int F = 10000;
    localparam int N = 6;
    localparam int D = 4;
    localparam int L = 20;
    localparam int T = F / 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key = '0;
    logic [N-1:0] key_state, key_press, key_release, key_long;

    key_debounce #(.F_CLK(F), .N_KEYS(N), .DEBOUNCE_MS(D), .LONG_MS(L)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_state(key_state),
        .key_press(key_press), .key_release(key_release), .key_long(key_long)
    );

    always #5 clk = ~clk;

    logic [N-1:0] m_state, e_press, e_rel, e_long, kd1, kd2, first_press;
    int m_start [N];
    int m_pedge [N];
    bit m_ldone [N];
    int n;
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_press [N];
    int cnt_rel [N];
    int cnt_long [N];
    int p_at [N];
    int r_at [N];
    int l_at [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Number of tick edges in the inclusive edge-index window [a, b].
    function automatic int ticks(input int a, input int b);
        return (b + 1) / T - a / T;
    endfunction

    task automatic model_reset();
        m_state = '1; kd1 = '1; kd2 = '1;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int i = 0; i < N; i++) begin
            m_start[i] = -1; m_pedge[i] = 0; m_ldone[i] = 1'b1;
        end
        n = 0;
    endtask

    task automatic clr_counts();
        first_press = '0;
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
        end
    endtask

    task automatic step(input int k);
        logic [N-1:0] ks, old;
        bit tk;
        repeat (k) begin
            @(posedge clk);
            ks = kd2; kd2 = kd1; kd1 = key;
            old = m_state;
            tk = (n % T == T - 1);
            e_press = '0; e_rel = '0; e_long = '0;
            for (int i = 0; i < N; i++) begin
                if (!old[i] && !m_ldone[i] && tk && ticks(m_pedge[i] + 1, n) == L) begin
                    e_long[i] = 1'b1;
                    m_ldone[i] = 1'b1;
                end
                if (ks[i] == old[i]) m_start[i] = -1;
                else begin
                    if (m_start[i] < 0) m_start[i] = n;
                    if (tk && ticks(m_start[i], n) == D) begin
                        m_state[i] = ks[i];
                        m_start[i] = -1;
                        if (ks[i]) e_rel[i] = 1'b1;
                        else begin
                            e_press[i] = 1'b1;
                            m_pedge[i] = n;
                            m_ldone[i] = 1'b0;
                        end
                    end
                end
            end
            n++;
            @(negedge clk);
            check("state", 32'(key_state), 32'(m_state));
            check("press", 32'(key_press), 32'(e_press));
            check("release", 32'(key_release), 32'(e_rel));
            check("long", 32'(key_long), 32'(e_long));
            if (key_press != 0 && first_press == 0) first_press = key_press;
            for (int i = 0; i < N; i++) begin
                if (key_press[i]) begin cnt_press[i]++; p_at[i] = n - 1; end
                if (key_release[i]) begin cnt_rel[i]++; r_at[i] = n - 1; end
                if (key_long[i]) begin cnt_long[i]++; l_at[i] = n - 1; end
            end
        end
    endtask

    task automatic rst_pulse(input int cyc);
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(key_state), 32'h3f);
        check("rst_strobes", 32'(key_press | key_release | key_long), 32'h0);
        repeat (cyc) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    int e;

    initial begin
        clr_counts();
        repeat (3) @(negedge clk);
        check("init_state", 32'(key_state), 32'h3f);
        check("init_strobes", 32'(key_press | key_release | key_long), 32'h0);
        key = 6'b111110;
        rst_n = 1'b1;
        model_reset();
        step(60);
        check("boot_press_cnt", 32'(cnt_press[0]), 32'd1);
        check("boot_press_lat", 32'(p_at[0] >= 31 && p_at[0] <= 41), 32'd1);
        key[0] = 1'b1;
        step(60);

        clr_counts();
        key[2] = 1'b0; e = n;
        step(100);
        check("press2_cnt", 32'(cnt_press[2]), 32'd1);
        check("press2_lat", 32'(p_at[2] - e + 1 >= 32 && p_at[2] - e + 1 <= 42), 32'd1);
        key[2] = 1'b1; e = n;
        step(100);
        check("rel2_cnt", 32'(cnt_rel[2]), 32'd1);
        check("rel2_lat", 32'(r_at[2] - e + 1 >= 32 && r_at[2] - e + 1 <= 42), 32'd1);

        clr_counts();
        for (int j = 0; j < 9; j++) begin
            key[1] = ~key[1]; e = n;
            step(7);
        end
        check("bounce_quiet", 32'(cnt_press[1] + cnt_rel[1]), 32'd0);
        step(60);
        check("bounce_press_cnt", 32'(cnt_press[1]), 32'd1);
        check("bounce_lat", 32'(p_at[1] - e + 1 >= 32 && p_at[1] - e + 1 <= 42), 32'd1);
        key[1] = 1'b1;
        step(60);

        clr_counts();
        key[4] = 1'b0;
        step(400);
        check("long_cnt", 32'(cnt_long[4]), 32'd1);
        check("long_lat", 32'(l_at[4] - p_at[4] >= 190 && l_at[4] - p_at[4] <= 210), 32'd1);
        key[4] = 1'b1;
        step(60);
        key[4] = 1'b0;
        step(260);
        check("long_rearm", 32'(cnt_long[4]), 32'd2);
        key[4] = 1'b1;
        step(60);

        clr_counts();
        key[0] = 1'b0; key[5] = 1'b0;
        step(60);
        check("simul_press", 32'(first_press), 32'h21);
        key = '1;
        step(60);

        clr_counts();
        key[3] = 1'b0;
        step(150);
        rst_pulse(3);
        clr_counts();
        step(300);
        check("rst_hold_press", 32'(cnt_press[3]), 32'd1);
        check("rst_hold_long", 32'(cnt_long[3]), 32'd1);
        check("rst_hold_lat", 32'(l_at[3] - p_at[3] >= 200), 32'd1);
        key[3] = 1'b1;
        step(60);

        for (int r = 0; r < 60; r++) begin
            key = key ^ N'($urandom_range(0, 63) & $urandom_range(0, 63));
            if (r == 30) rst_pulse($urandom_range(1, 5));
            step($urandom_range(1, 80));
        end
        key = '1;
        step(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
